// File: rtl/drive_cmd_pkg.sv
// Drive-command encoding and the ASCII command alphabet. The command_receiver
// and the transmitter-side command_translator both use these definitions.
package drive_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_STOP    = 3'd0,
        CMD_FORWARD = 3'd1,
        CMD_BACK    = 3'd2,
        CMD_LEFT    = 3'd3,
        CMD_RIGHT   = 3'd4
    } cmd_t;

    localparam logic [7:0] ASCII_S = 8'h53;
    localparam logic [7:0] ASCII_F = 8'h46;
    localparam logic [7:0] ASCII_B = 8'h42;
    localparam logic [7:0] ASCII_L = 8'h4C;
    localparam logic [7:0] ASCII_R = 8'h52;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic ok;
        cmd_t cmd;
    } decode_t;

    function automatic decode_t decode_byte(input logic [7:0] b);
        decode_t d;
        d.ok  = 1'b1;
        d.cmd = CMD_STOP;
        case (b)
            ASCII_S: d.cmd = CMD_STOP;
            ASCII_F: d.cmd = CMD_FORWARD;
            ASCII_B: d.cmd = CMD_BACK;
            ASCII_L: d.cmd = CMD_LEFT;
            ASCII_R: d.cmd = CMD_RIGHT;
            default: d.ok  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling with a down-counter,
// one-cycle byte_valid / frame_error strobes at the stop-bit sample.
//   state        | meaning
//   RX_IDLE      | line idle, watching for a high-to-low transition
//   RX_START     | half a bit in, confirm start bit is still low
//   RX_DATA      | sampling 8 data bits, LSB first
//   RX_STOP      | sampling stop bit
//   RX_WAIT_IDLE | bad stop bit seen, wait for the line to return high
module uart_rx
    import drive_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT + 1);

    logic          sync_meta;
    logic          sync_line;
    logic          line_prev;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic          expire;
    logic          fall;

    // Terminal count of 1 makes a load of N span exactly N cycles.
    assign expire  = (cnt_q == CW'(1));
    assign fall    = line_prev & ~sync_line;
    assign rx_byte = shift_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
            line_prev <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_q     <= '0;
        end else begin
            sync_meta <= uart_in;
            sync_line <= sync_meta;
            line_prev <= sync_line;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        shift_d     = shift_q;
        bit_d       = bit_q;
        byte_valid  = 1'b0;
        frame_error = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = CW'(HALF_BIT);
                end
            end
            RX_START: begin
                if (expire) begin
                    if (!sync_line) begin
                        state_d = RX_DATA;
                        cnt_d   = CW'(CLKS_PER_BIT);
                        bit_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (expire) begin
                    shift_d = {sync_line, shift_q[7:1]};
                    cnt_d   = CW'(CLKS_PER_BIT);
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (expire) begin
                    if (sync_line) begin
                        byte_valid = 1'b1;
                        state_d    = RX_IDLE;
                    end else begin
                        frame_error = 1'b1;
                        state_d     = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (sync_line) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/command_receiver.sv
// Serial drive-command receiver: decodes ASCII command bytes from uart_rx and
// holds them behind a valid/ready handshake with error strobes.
module command_receiver
    import drive_cmd_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_in,
    output logic [2:0] command,
    output logic       valid,
    input  logic       ready,
    output logic       frame_error,
    output logic       bad_char,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_frame_error;
    decode_t    dec;
    logic       load;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .uart_in    (uart_in),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_error(rx_frame_error)
    );

    always_comb begin
        dec  = decode_byte(rx_byte);
        load = byte_valid & dec.ok;
    end

    // A new load wins over consumption; overrun only when the old one was never taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            command     <= 3'd0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            bad_char    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= rx_frame_error;
            bad_char    <= byte_valid & ~dec.ok;
            overrun     <= load & valid & ~ready;
            if (load) begin
                command <= dec.cmd;
                valid   <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_command_receiver.sv
// Directed bench for command_receiver at default 50 MHz / 115200 baud.
module tb_command_receiver;
    import drive_cmd_pkg::*;

    localparam int CPB = 434;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_in = 1'b1;
    logic       ready = 1'b0;
    logic [2:0] command;
    logic       valid;
    logic       frame_error;
    logic       bad_char;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int fe_n = 0, bc_n = 0, ov_n = 0, long_n = 0;
    logic fe_p = 1'b0, bc_p = 1'b0, ov_p = 1'b0;
    int fe0, bc0, ov0;

    always #10 clk = ~clk;

    command_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .uart_in    (uart_in),
        .command    (command),
        .valid      (valid),
        .ready      (ready),
        .frame_error(frame_error),
        .bad_char   (bad_char),
        .overrun    (overrun)
    );

    // Pulse counters and back-to-back pulse detection.
    always @(negedge clk) begin
        if (frame_error) fe_n <= fe_n + 1;
        if (bad_char)    bc_n <= bc_n + 1;
        if (overrun)     ov_n <= ov_n + 1;
        if ((frame_error && fe_p) || (bad_char && bc_p) || (overrun && ov_p))
            long_n <= long_n + 1;
        fe_p <= frame_error;
        bc_p <= bad_char;
        ov_p <= overrun;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_drive(input logic v, input int n);
        uart_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the stop-bit level is applied.
    task automatic send_to_stop(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        bit_drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_drive(b[i], CPB);
        uart_in = stop;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_to_stop(b, stop);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic consume;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] bb;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_command", command, 0);
        check("rst_valid", valid, 0);
        check("rst_frame_error", frame_error, 0);
        check("rst_bad_char", bad_char, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_rx_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));

        // 'F' with ready low; stop-bit sample lands 220 cycles into the stop bit.
        send_to_stop(ASCII_F, 1'b1);
        repeat (219) @(posedge clk);
        #1;
        check("f_valid_before_sample", valid, 0);
        @(posedge clk);
        #1;
        check("f_valid_after_sample", valid, 1);
        check("f_command", command, 1);
        repeat (214) @(posedge clk);
        #1;
        ready = 1'b1;
        @(negedge clk);
        check("f_valid_while_ready", valid, 1);
        @(posedge clk);
        #1;
        ready = 1'b0;
        check("f_valid_consumed", valid, 0);
        check("f_command_held", command, 1);

        // 'R' with a low stop bit, then line high and 'S'.
        fe0 = fe_n;
        send_frame(ASCII_R, 1'b0);
        uart_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("fe_pulse_count", 32'(fe_n - fe0), 1);
        check("fe_valid_low", valid, 0);
        check("fe_rx_back_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
        send_frame(ASCII_S, 1'b1);
        check("s_command", command, 0);
        check("s_valid", valid, 1);
        consume();

        // 100-cycle glitch is shorter than half a bit.
        fe0 = fe_n; bc0 = bc_n; ov0 = ov_n;
        uart_in = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        uart_in = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check("glitch_no_pulses", 32'((fe_n - fe0) + (bc_n - bc0) + (ov_n - ov0)), 0);
        check("glitch_valid", valid, 0);
        check("glitch_rx_idle", 32'(dut.u_rx.state_q), 32'(RX_IDLE));

        // 'L' then 'R' unconsumed -> overrun.
        ov0 = ov_n;
        send_frame(ASCII_L, 1'b1);
        check("l_command", command, 3);
        send_frame(ASCII_R, 1'b1);
        check("ovr_pulse_count", 32'(ov_n - ov0), 1);
        check("ovr_command", command, 4);
        check("ovr_valid", valid, 1);
        consume();

        // Same pair with ready held high -> no overrun.
        ov0 = ov_n;
        ready = 1'b1;
        send_frame(ASCII_L, 1'b1);
        check("rdy_l_command", command, 3);
        send_frame(ASCII_R, 1'b1);
        ready = 1'b0;
        check("rdy_no_overrun", 32'(ov_n - ov0), 0);
        check("rdy_command", command, 4);
        check("rdy_valid_consumed", valid, 0);

        // Consume of 'L' in the same cycle 'R' loads -> no overrun.
        ov0 = ov_n;
        send_frame(ASCII_L, 1'b1);
        send_to_stop(ASCII_R, 1'b1);
        repeat (219) @(posedge clk);
        #1;
        ready = 1'b1;
        @(negedge clk);
        check("same_cyc_pre_valid", valid, 1);
        check("same_cyc_pre_command", command, 3);
        @(posedge clk);
        #1;
        ready = 1'b0;
        check("same_cyc_valid", valid, 1);
        check("same_cyc_command", command, 4);
        repeat (214) @(posedge clk);
        #1;
        check("same_cyc_no_overrun", 32'(ov_n - ov0), 0);

        // 'X' is outside the alphabet; pending 'R' must survive.
        bc0 = bc_n;
        send_frame(8'h58, 1'b1);
        check("x_bad_char_count", 32'(bc_n - bc0), 1);
        check("x_command_kept", command, 4);
        check("x_valid_kept", valid, 1);

        // One-cycle reset in the middle of data bit 4 of 'B'.
        bb = ASCII_B;
        @(posedge clk);
        #1;
        bit_drive(1'b0, CPB);
        for (int i = 0; i < 4; i++) bit_drive(bb[i], CPB);
        bit_drive(bb[4], 200);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_valid_cleared", valid, 0);
        check("midrst_command_cleared", command, 0);
        bit_drive(bb[4], CPB - 201);
        for (int i = 5; i < 8; i++) bit_drive(bb[i], CPB);
        bit_drive(1'b1, CPB);
        repeat (5000) @(posedge clk);
        #1;
        check("midrst_no_valid", valid, 0);
        send_frame(ASCII_B, 1'b1);
        check("b_command", command, 2);
        check("b_valid", valid, 1);

        check("pulse_width_single", 32'(long_n), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/command_receiver.md
COMMAND_RECEIVER -- requirements
Module: command_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (434 at defaults).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart_in  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port command  output  3  decoded drive command.
REQ-007 SHALL have port valid  output  1  command holds a new, unconsumed command.
REQ-008 SHALL have port ready  input  1  consumer accepts command when valid && ready.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port bad_char  output  1  one-cycle pulse on a received byte outside the command alphabet.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when an unaccepted command is overwritten.

Function
REQ-012 SHALL pass uart_in through a 2-flop synchronizer; all sampling uses the synchronized signal.
REQ-013 SHALL implement receiver states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE -> START on a synchronized high-to-low transition; the bit counter loads CLKS_PER_BIT/2.
REQ-015 START: at counter expiry, line low -> DATA with counter = CLKS_PER_BIT; line high -> IDLE (false start, no outputs).
REQ-016 DATA: sample at each CLKS_PER_BIT expiry; shift 8 bits LSB first; -> STOP after bit 7.
REQ-017 STOP: at expiry, line high -> byte complete, -> IDLE; line low -> frame_error pulse, byte discarded, -> WAIT_IDLE.
REQ-018 WAIT_IDLE -> IDLE once the synchronized line reads high; no start detection before then.
REQ-019 SHALL decode completed bytes: 'S'(0x53)->0, 'F'(0x46)->1, 'B'(0x42)->2, 'L'(0x4C)->3, 'R'(0x52)->4; codes 5-7 are never produced.
REQ-020 Any other byte SHALL pulse bad_char for one cycle and leave command/valid unchanged.
REQ-021 A valid byte SHALL load command and raise valid on the cycle after the stop-bit sample.
REQ-022 valid SHALL stay high and command stable until the cycle after valid && ready, then valid drops.
REQ-023 If a new command loads while valid=1 and ready=0, the new command SHALL overwrite it, valid stays 1, and overrun pulses.
REQ-024 If a new command loads in the same cycle as valid && ready, the new command SHALL load, valid stays 1, and overrun stays 0.
REQ-025 frame_error, bad_char and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-026 While reset is high, the FSM SHALL go to IDLE; counters and the shift register clear; synchronizer flops load 1.
REQ-027 Reset values SHALL be command=0, valid=0, frame_error=0, bad_char=0, overrun=0.
REQ-028 Reset mid-frame SHALL discard the partial byte; the next falling edge after reset starts a fresh frame.

Structure
REQ-029 The shared package drive_cmd_pkg SHALL hold the 3-bit command typedef (CMD_STOP..CMD_RIGHT) and the five ASCII constants, for shared use with the transmitter-side command_translator.
REQ-030 The byte-level receiver (REQ-012..018) SHALL be a sub-module uart_rx (outputs byte, byte_valid pulse, frame_error); decode and handshake stay in command_receiver.

Verification
REQ-031 With ready=0, 'F' 0x46 at 115200 -> command=1, valid=1 within 2 cycles of the stop-bit mid-sample; ready=1 for one cycle -> valid=0 on the next cycle.
REQ-032 'R' 0x52 with the stop bit driven low -> one frame_error pulse, valid stays 0; line returns high, then 'S' -> command=0, valid=1.
REQ-033 uart_in low for 100 cycles (< CLKS_PER_BIT/2), then high -> no output activity, FSM back in IDLE.
REQ-034 'L' then 'R' back-to-back with ready=0 -> one overrun pulse, command=4, valid=1; repeat with ready=1 held -> no overrun.
REQ-035 'X' 0x58 -> one bad_char pulse, command/valid unchanged.
REQ-036 reset asserted for 1 cycle during DATA bit 4 of 'B' -> no valid; a following 'B' -> command=2, valid=1.
